// File: rtl/mem_arbiter.sv
// Two-to-one cacheline arbiter (I-cache / D-cache) in front of one physical-memory port.
// Optional instruction-starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int unsigned LINE_W     = 256,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state, state_next;

  logic              cmd_we;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  logic d_req;
  logic grant_i;
  logic grant_d;
  logic starved;

  if (STARVE_MAX < 1) begin : g_bad_cfg
    $error("mem_arbiter: STARVE_MAX must be >= 1");
  end

  assign d_req = d_read | d_write;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned STREAK_W = $clog2(STARVE_MAX + 1);

  logic [STREAK_W-1:0] streak;

  assign starved = (streak == STREAK_W'(STARVE_MAX));

  // Counts data grants that overtook a waiting instruction read; saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (grant_i) begin
      streak <= '0;
    end else if (grant_d && i_read) begin
      if (!starved) begin
        streak <= streak + STREAK_W'(1);
      end
    end else if (state == IDLE && !i_read) begin
      streak <= '0;
    end
  end
`else
  assign starved = 1'b0;
`endif

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && !(starved && i_read)) begin
          grant_d    = 1'b1;
          state_next = SERVE_D;
        end else if (i_read) begin
          grant_i    = 1'b1;
          state_next = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command is captured once at grant; requester inputs are ignored afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_we  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_d) begin
      cmd_we <= d_write;
      addr_q <= d_address;
      if (d_write) begin
        wdata_q <= d_wdata;
      end
    end else if (grant_i) begin
      cmd_we <= 1'b0;
      addr_q <= i_address;
    end
  end

  assign busy         = (state != IDLE);
  assign pmem_read    = busy & ~cmd_we;
  assign pmem_write   = busy & cmd_we;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_resp  = (state == SERVE_I) & pmem_resp;
  assign d_resp  = (state == SERVE_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule
